// File: rtl/glyph_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | glyph_pkg : shared geometry constants and sequencer state encoding |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package glyph_pkg;

   localparam int CELL_W   = 8;
   localparam int CELL_H   = 12;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int GX_W     = $clog2(CELL_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      VBLANK = 2'd2
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cell_row_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cell_row_counter : incremental vpos/CELL_H and vpos mod CELL_H     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cell_row_counter
   import glyph_pkg::*;
#(
   parameter int CELL_H = glyph_pkg::CELL_H
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_start,
   input  logic       frame_start,
   input  logic       enable,
   output logic [5:0] y_block,
   output logic [3:0] g_y
);

   logic [5:0] r_y_block;
   logic [3:0] r_g_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_block <= 6'd0;
         r_g_y     <= 4'd0;
      end else if (line_start) begin
         if (frame_start) begin
            r_y_block <= 6'd0;
            r_g_y     <= 4'd0;
         end else if (enable) begin
            if (r_g_y == 4'(CELL_H - 1)) begin
               r_g_y     <= 4'd0;
               r_y_block <= r_y_block + 6'd1;
            end else begin
               r_g_y <= r_g_y + 4'd1;
            end
         end
      end
   end

   assign y_block = r_y_block;
   assign g_y     = r_g_y;

endmodule
`default_nettype wire

// File: rtl/glyph_cell_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | glyph_cell_sequencer : cell coordinates and animation frame count  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module glyph_cell_sequencer
   import glyph_pkg::*;
#(
   parameter int H_ACTIVE  = glyph_pkg::H_ACTIVE,
   parameter int V_ACTIVE  = glyph_pkg::V_ACTIVE,
   parameter int CELL_H    = glyph_pkg::CELL_H,
   parameter int FRAME_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       display_on,
   input  logic       run,
   input  logic       step,
   output logic [6:0] x_block,
   output logic [2:0] g_x,
   output logic [5:0] y_block,
   output logic [3:0] g_y,
   output logic       cell_valid,
   output logic [9:0] frame_cnt,
   output logic       frame_tick
);

   seq_state_t r_state;
   seq_state_t w_state_next;

   logic [6:0] r_x_block;
   logic [2:0] r_g_x;
   logic       r_cell_valid;
   logic       r_frame_tick;
   logic [9:0] r_frame_cnt;
   logic [3:0] r_presc;
   logic       r_step_pend;
   logic       r_step_prev;

   logic w_line_start;
   logic w_frame_start;
   logic w_frame_end;
   logic w_tick;
   logic w_step_edge;
   logic w_hvis;

   assign w_line_start  = (hpos == 10'd0);
   assign w_frame_start = w_line_start && (vpos == 10'd0);
   assign w_frame_end   = w_line_start && (vpos == 10'(V_ACTIVE));
   assign w_tick        = (r_state == ACTIVE) && w_frame_end;
   assign w_step_edge   = step && !r_step_prev;
   assign w_hvis        = (hpos < 10'(H_ACTIVE));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_frame_start) w_state_next = ACTIVE;
         ACTIVE:  if (w_frame_end)   w_state_next = VBLANK;
         VBLANK:  if (w_frame_start) w_state_next = ACTIVE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_x_block    <= 7'd0;
         r_g_x        <= 3'd0;
         r_cell_valid <= 1'b0;
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= 10'd0;
         r_presc      <= 4'd0;
         r_step_pend  <= 1'b0;
         r_step_prev  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_step_prev  <= step;
         r_frame_tick <= w_tick;
         // An edge arriving on the tick itself survives into the next frame.
         r_step_pend  <= w_step_edge || (r_step_pend && !w_tick);

         if (w_state_next == IDLE) begin
            r_x_block    <= 7'd0;
            r_g_x        <= 3'd0;
            r_cell_valid <= 1'b0;
         end else begin
            r_x_block    <= hpos[9:GX_W];
            r_g_x        <= hpos[GX_W-1:0];
            r_cell_valid <= display_on && w_hvis && (w_state_next == ACTIVE);
         end

         if (w_tick) begin
            if (run) begin
               if (r_presc == 4'(FRAME_DIV - 1)) begin
                  r_presc     <= 4'd0;
                  r_frame_cnt <= r_frame_cnt + 10'd1;
               end else begin
                  r_presc <= r_presc + 4'd1;
               end
            end else if (r_step_pend) begin
               r_frame_cnt <= r_frame_cnt + 10'd1;
            end
         end
      end
   end

   cell_row_counter #(
      .CELL_H (CELL_H)
   ) u_rows (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_start  (w_line_start),
      .frame_start (w_frame_start),
      .enable      (r_state == ACTIVE),
      .y_block     (y_block),
      .g_y         (g_y)
   );

   assign x_block    = r_x_block;
   assign g_x        = r_g_x;
   assign cell_valid = r_cell_valid;
   assign frame_cnt  = r_frame_cnt;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_glyph_cell_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_glyph_cell_sequencer : raster stimulus against a frame model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_glyph_cell_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] hpos = 10'd5;
   logic [9:0] vpos = 10'd7;
   logic       display_on = 1'b1;
   logic       run = 1'b1;
   logic       step = 1'b0;

   logic [6:0] x_block, x_block4;
   logic [2:0] g_x, g_x4;
   logic [5:0] y_block, y_block4;
   logic [3:0] g_y, g_y4;
   logic       cell_valid, cell_valid4;
   logic [9:0] frame_cnt, frame_cnt4;
   logic       frame_tick, frame_tick4;

   glyph_cell_sequencer dut (
      .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .run(run), .step(step), .x_block(x_block), .g_x(g_x), .y_block(y_block),
      .g_y(g_y), .cell_valid(cell_valid), .frame_cnt(frame_cnt), .frame_tick(frame_tick)
   );

   glyph_cell_sequencer #(.FRAME_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .run(run), .step(step), .x_block(x_block4), .g_x(g_x4), .y_block(y_block4),
      .g_y(g_y4), .cell_valid(cell_valid4), .frame_cnt(frame_cnt4), .frame_tick(frame_tick4)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: 0 = waiting for first frame start, 1 = visible, 2 = blanking.
   int m_mode = 0;
   int e_x = 0, e_gx = 0, e_y = 0, e_gy = 0, e_cv = 0, e_tick = 0;
   int e_cnt = 0, e_cnt4 = 0, m_presc4 = 0;
   bit m_pend = 0, m_prev = 0, m_edge = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; e_x = 0; e_gx = 0; e_y = 0; e_gy = 0; e_cv = 0; e_tick = 0;
         e_cnt = 0; e_cnt4 = 0; m_presc4 = 0; m_pend = 0; m_prev = 0;
      end else begin
         e_tick = (m_mode == 1 && hpos == 0 && vpos == 480) ? 1 : 0;
         if (hpos == 0 && vpos == 0) m_mode = 1;
         else if (e_tick == 1) m_mode = 2;
         if (m_mode == 0) begin
            e_x = 0; e_gx = 0; e_y = 0; e_gy = 0; e_cv = 0;
         end else begin
            e_x  = hpos / 8;
            e_gx = hpos % 8;
            e_y  = vpos / 12;
            e_gy = vpos % 12;
            e_cv = (display_on && m_mode == 1) ? 1 : 0;
         end
         m_edge = step && !m_prev;
         m_prev = step;
         if (e_tick == 1) begin
            if (run) begin
               e_cnt = (e_cnt + 1) % 1024;
               m_presc4++;
               if (m_presc4 == 4) begin
                  m_presc4 = 0;
                  e_cnt4 = (e_cnt4 + 1) % 1024;
               end
            end else if (m_pend) begin
               e_cnt  = (e_cnt + 1) % 1024;
               e_cnt4 = (e_cnt4 + 1) % 1024;
            end
         end
         m_pend = m_edge || (m_pend && e_tick == 0);
      end
   end

   always @(negedge clk) begin
      chk("x_block", x_block, e_x);
      chk("g_x", g_x, e_gx);
      chk("cell_valid", cell_valid, e_cv);
      chk("cell_valid_div4", cell_valid4, e_cv);
      chk("frame_tick", frame_tick, e_tick);
      chk("frame_tick_div4", frame_tick4, e_tick);
      chk("frame_cnt", frame_cnt, e_cnt);
      chk("frame_cnt_div4", frame_cnt4, e_cnt4);
      if (e_cv == 1 || m_mode == 0) begin
         chk("y_block", y_block, e_y);
         chk("g_y", g_y, e_gy);
      end
   end

   bit rnd_step = 0;
   int pin_cnt = 1;

   task automatic cyc(input int h, input int v, input bit d);
      @(negedge clk);
      hpos = 10'(h);
      vpos = 10'(v);
      display_on = d;
      if (rnd_step && $urandom_range(0, 31) == 0) step = ~step;
   endtask

   // pin: 0 = none, 1 = literal row/tick values, 2 = expect no tick at vpos 480
   task automatic line(input int v, input int pin);
      int n;
      cyc(0, v, v < 480);
      if (pin != 0) begin
         @(posedge clk);
         #1;
         if (v == 480) begin
            chk("tick_at_480", frame_tick, (pin == 1) ? 1 : 0);
            if (pin == 1) chk("cnt_at_480", frame_cnt, pin_cnt);
         end
         if (pin == 1) begin
            case (v)
               0:   begin chk("cv_v0", cell_valid, 1); chk("y_v0", y_block, 0); chk("gy_v0", g_y, 0); end
               11:  begin chk("gy_v11", g_y, 11); chk("y_v11", y_block, 0); end
               12:  begin chk("gy_v12", g_y, 0); chk("y_v12", y_block, 1); end
               479: begin chk("y_v479", y_block, 39); chk("gy_v479", g_y, 11); end
               default: ;
            endcase
         end
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) cyc($urandom_range(1, 639), v, v < 480);
      cyc(700, v, 0);
   endtask

   task automatic full_frame(input int pin);
      for (int v = 0; v < 525; v++) line(v, pin);
   endtask

   task automatic fast_frame();
      cyc(0, 0, 1);
      cyc(700, 0, 0);
      cyc(0, 480, 0);
      cyc(700, 480, 0);
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      chk("rst_x_block", x_block, 0);
      chk("rst_cell_valid", cell_valid, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      cyc(3, 7, 1);
      cyc(9, 7, 1);
      chk("idle_cell_valid", cell_valid, 0);

      full_frame(1);
      full_frame(0);
      repeat (6) fast_frame();
      chk("cnt_after_8", frame_cnt, 8);
      chk("cnt4_after_8", frame_cnt4, 2);

      run = 1'b0;
      cyc(0, 0, 1);
      repeat (3) begin
         cyc(700, 0, 0); step = 1'b1;
         cyc(700, 0, 0); step = 1'b0;
      end
      cyc(0, 480, 0);
      cyc(700, 480, 0);
      chk("step_collapse", frame_cnt, 9);
      chk("step_collapse_div4", frame_cnt4, 3);
      fast_frame();
      chk("step_consumed", frame_cnt, 9);
      cyc(0, 0, 1);
      cyc(700, 0, 0);
      cyc(0, 480, 0); step = 1'b1;
      cyc(700, 480, 0);
      chk("step_on_tick_held", frame_cnt, 9);
      cyc(0, 0, 1); step = 1'b0;
      cyc(700, 0, 0);
      cyc(0, 480, 0);
      cyc(700, 480, 0);
      chk("step_on_tick_applied", frame_cnt, 10);
      chk("step_on_tick_div4", frame_cnt4, 4);

      run = 1'b1;
      guard = 0;
      while (e_cnt != 1023 && guard < 2000) begin
         fast_frame();
         guard++;
      end
      chk("cnt_pre_wrap", frame_cnt, 1023);
      fast_frame();
      chk("cnt_wrap", frame_cnt, 0);

      rnd_step = 1;
      for (int f = 0; f < 3; f++) begin
         run = 1'($urandom_range(0, 1));
         full_frame(0);
      end
      for (int f = 0; f < 200; f++) begin
         run = 1'($urandom_range(0, 1));
         fast_frame();
      end
      rnd_step = 0;
      step = 1'b0;

      run = 1'b1;
      for (int v = 0; v < 200; v++) line(v, 0);
      cyc(0, 200, 1);
      cyc(100, 200, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_x_block", x_block, 0);
      chk("async_cell_valid", cell_valid, 0);
      chk("async_y_block", y_block, 0);
      chk("async_frame_cnt", frame_cnt, 0);
      cyc(50, 200, 1);
      cyc(60, 200, 1);
      rst_n = 1'b1;
      for (int v = 201; v < 525; v++) line(v, 2);
      full_frame(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
